// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulus up/down counter.
package counter_pkg;

  typedef enum logic {RUN, HALT} cnt_state_t;

  // Terminal value for the current direction: MODULUS-1 counting up, 0 counting down.
  function automatic int unsigned terminal_value(input int unsigned modulus, input logic up);
    return up ? modulus - 1 : 0;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescale counter: emits a one-cycle tick on every PRESCALE-th enabled cycle.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clr};
    assign tick = en;
  end else begin : g_count
    localparam int unsigned CntW = $clog2(PRESCALE);
    localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == Last);

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en) begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulus up/down counter with load, prescaler, one-shot halt and
// a registered terminal-count pulse.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("MODULUS must lie in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic             running;
  logic             tick;
  logic             step;
  logic             at_term;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] load_clamped;

  assign running      = (state_q == RUN);
  assign term_val     = WIDTH'(terminal_value(MODULUS, up));
  assign at_term      = (cnt_q == term_val);
  assign load_clamped = (load_val > MaxVal) ? MaxVal : load_val;
  assign step         = running && tick;

  // The prescaler is frozen while halted so a resumed count starts cleanly after load.
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (load),
    .en   (en && running),
    .tick (tick)
  );

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    if (load) begin
      cnt_d   = load_clamped;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (step) begin
      if (at_term) begin
        tc_d = 1'b1;
        if (one_shot) begin
          done_d  = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = up ? '0 : MaxVal;
        end
      end else begin
        cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= RUN;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign q    = cnt_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3) share stimulus and are
// compared every cycle against a behavioural model.
module tb_mod_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0, one_shot = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q1, q3;
  logic         tc1, tc3, done1, done3;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .one_shot(one_shot), .q(q1), .tc(tc1), .done(done1)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .one_shot(one_shot), .q(q3), .tc(tc3), .done(done3)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         done;
  } exp_t;

  exp_t exp_q1[$];
  exp_t exp_q3[$];
  int   errors = 0;
  int   checks = 0;

  // Model state per instance: index 0 is PRESCALE=1, index 1 is PRESCALE=3.
  int m_q[2], m_p[2], m_halt[2], m_done[2], m_tc[2];

  function automatic int pre_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_step(input int k);
    int p;
    int term;
    p = pre_of(k);
    if (reset) begin
      m_q[k] = 0; m_p[k] = 0; m_halt[k] = 0; m_done[k] = 0; m_tc[k] = 0;
    end else if (load) begin
      m_q[k] = (int'(load_val) < M - 1) ? int'(load_val) : M - 1;
      m_p[k] = 0; m_halt[k] = 0; m_done[k] = 0; m_tc[k] = 0;
    end else begin
      m_tc[k] = 0;
      if (en && m_halt[k] == 0) begin
        m_p[k] = m_p[k] + 1;
        if (m_p[k] == p) begin
          m_p[k] = 0;
          term = up ? M - 1 : 0;
          if (m_q[k] == term) begin
            m_tc[k] = 1;
            if (one_shot) begin
              m_done[k] = 1;
              m_halt[k] = 1;
            end else begin
              m_q[k] = up ? 0 : M - 1;
            end
          end else begin
            m_q[k] = up ? m_q[k] + 1 : m_q[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lv, input logic os);
    exp_t x;
    reset = r; en = e; up = u; load = l; load_val = lv; one_shot = os;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      x.q = W'(m_q[k]); x.tc = m_tc[k][0]; x.done = m_done[k][0];
      if (k == 0) exp_q1.push_back(x);
      else exp_q3.push_back(x);
    end
    @(posedge clk);
    #2;
  endtask

  exp_t e1, e3;
  always begin
    @(posedge clk);
    #1;
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      checks++;
      if ({q1, tc1, done1} !== e1) begin
        errors++;
        $display("FAIL presc1 t=%0t got q=%0d tc=%b done=%b expected q=%0d tc=%b done=%b",
                 $time, q1, tc1, done1, e1.q, e1.tc, e1.done);
      end
    end
    if (exp_q3.size() > 0) begin
      e3 = exp_q3.pop_front();
      checks++;
      if ({q3, tc3, done3} !== e3) begin
        errors++;
        $display("FAIL presc3 t=%0t got q=%0d tc=%b done=%b expected q=%0d tc=%b done=%b",
                 $time, q3, tc3, done3, e3.q, e3.tc, e3.done);
      end
    end
  end

  initial begin
    #2;
    // Reset wins over a simultaneous load.
    repeat (2) cycle(1, 1, 1, 1, 4'd5, 0);
    // Free-run up through two wraps.
    repeat (25) cycle(0, 1, 1, 0, 4'd0, 0);
    // Load 3 and count down through 0 to 9.
    cycle(0, 1, 1, 1, 4'd3, 0);
    repeat (15) cycle(0, 1, 0, 0, 4'd0, 0);
    // Load with en high takes no step.
    cycle(0, 1, 0, 1, 4'd6, 0);
    cycle(0, 0, 0, 0, 4'd0, 0);
    // One-shot from 7 up, then idle en cycles while halted.
    cycle(0, 1, 1, 1, 4'd7, 1);
    repeat (14) cycle(0, 1, 1, 0, 4'd0, 1);
    cycle(0, 1, 1, 0, 4'd0, 0);
    // Load 0 clears done and counting resumes.
    cycle(0, 1, 1, 1, 4'd0, 0);
    repeat (7) cycle(0, 1, 1, 0, 4'd0, 0);
    // en low freezes prescaler and count.
    repeat (5) cycle(0, 0, 1, 0, 4'd0, 0);
    repeat (7) cycle(0, 1, 1, 0, 4'd0, 0);
    // Clamp of an out-of-range load value.
    cycle(0, 0, 1, 1, 4'd12, 0);
    cycle(0, 0, 1, 0, 4'd0, 0);
    cycle(0, 1, 1, 1, 4'd15, 0);
    repeat (4) cycle(0, 1, 1, 0, 4'd0, 0);
    // Reset mid-count, then check the prescaler restarts from zero.
    cycle(0, 1, 1, 1, 4'd5, 0);
    repeat (4) cycle(0, 1, 1, 0, 4'd0, 0);
    cycle(1, 1, 1, 0, 4'd0, 0);
    repeat (7) cycle(0, 1, 1, 0, 4'd0, 0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, e, l, os;
      logic [W-1:0] lv;
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 7);
      e  = ($urandom_range(0, 99) < 80);
      os = ($urandom_range(0, 99) < 35);
      lv = W'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 10) up = ~up;
      cycle(r, e, up, l, lv, os);
    end
    @(posedge clk);
    #3;
    checks++;
    if (exp_q1.size() != 0 || exp_q3.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending expected 0/0", exp_q1.size(), exp_q3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
